// File: rtl/mips_pkg.sv
// Shared MIPS definitions: run-controller state encodings, drain default and the
// HALT opcode used by decode.
package mips_pkg;

    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int DRAIN_CYCLES_DEFAULT = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'b000;
    localparam state_t ST_RUN   = 3'b001;
    localparam state_t ST_STEP  = 3'b010;
    localparam state_t ST_DRAIN = 3'b011;
    localparam state_t ST_DONE  = 3'b100;

endpackage

// File: rtl/pipeline_run_controller_if.sv
// Command/status bundle between the debug front end and pipeline_run_controller.
interface pipeline_run_controller_if
    import mips_pkg::*;
#(
    parameter int NB_COUNT = 32
);

    logic                i_start;
    logic                i_step;
    logic                i_abort;
    logic                i_clear;
    logic                i_halt_detected;
    logic                o_enable;
    state_t              o_state;
    logic                o_done;
    logic                o_timeout;
    logic [NB_COUNT-1:0] o_cycle_count;

    modport slave (
        input  i_start, i_step, i_abort, i_clear, i_halt_detected,
        output o_enable, o_state, o_done, o_timeout, o_cycle_count
    );

    modport master (
        output i_start, i_step, i_abort, i_clear, i_halt_detected,
        input  o_enable, o_state, o_done, o_timeout, o_cycle_count
    );

endinterface

// File: rtl/pipeline_run_controller_counter.sv
// Executed-cycle counter plus optional RUN/DRAIN watchdog
// (built only with PIPELINE_RUN_CTRL_TIMEOUT_EN).
module enable_cycle_counter #(
    parameter int NB_COUNT       = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_clear,
    input  logic                i_run_active,
    output logic [NB_COUNT-1:0] o_cycle_count,
    output logic                o_expire
);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear)
            o_cycle_count <= '0;
        else if (i_enable)
            o_cycle_count <= o_cycle_count + 1'b1;
    end

`ifdef PIPELINE_RUN_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Leaving RUN/DRAIN (IDLE, STEP or DONE) restarts the consecutive count.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run_active)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign o_expire = i_run_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign o_expire = i_run_active & 1'b0;
`endif

endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/drain sequencer driving the single stage enable of the 5-stage MIPS pipeline.
// Optional watchdog: PIPELINE_RUN_CTRL_TIMEOUT_EN.
module pipeline_run_controller
    import mips_pkg::*;
#(
    parameter int NB_COUNT       = 32,
    parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    pipeline_run_controller_if.slave bus
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain
        $error("DRAIN_CYCLES must be within 1..7");
    end

    state_t              state, state_n;
    logic                enable, enable_n;
    logic                halt_flag, halt_n;
    logic                timeout, timeout_n;
    logic [2:0]          drain_cnt, drain_n;
    logic                halt_take;
    logic                wd_expire;
    logic                clear_done;
    logic [NB_COUNT-1:0] cycle_count;

    assign halt_take  = enable && bus.i_halt_detected && !halt_flag;
    assign clear_done = (state == ST_DONE) && bus.i_clear;

    always_comb begin
        state_n   = state;
        enable_n  = 1'b0;
        halt_n    = halt_flag;
        drain_n   = drain_cnt;
        timeout_n = timeout;
        if (bus.i_abort && state != ST_IDLE && state != ST_DONE) begin
            state_n = ST_DONE;
        end else if (wd_expire) begin
            state_n   = ST_DONE;
            timeout_n = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_n  = ST_RUN;
                        enable_n = 1'b1;
                    end else if (bus.i_step) begin
                        state_n  = ST_STEP;
                        enable_n = 1'b1;
                    end
                end
                ST_RUN: begin
                    enable_n = 1'b1;
                    if (halt_take) begin
                        halt_n  = 1'b1;
                        drain_n = 3'(DRAIN_CYCLES);
                        state_n = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_n = drain_cnt - 3'd1;
                    if (drain_cnt == 3'd1) state_n = ST_DONE;
                    else                   enable_n = 1'b1;
                end
                ST_STEP: begin
                    // Once halted, each granted step spends one drain cycle.
                    if (enable && halt_flag) begin
                        drain_n = drain_cnt - 3'd1;
                    end else if (halt_take) begin
                        halt_n  = 1'b1;
                        drain_n = 3'(DRAIN_CYCLES);
                    end
                    if (enable && halt_flag && drain_cnt == 3'd1) begin
                        state_n = ST_DONE;
                    end else if (bus.i_start) begin
                        state_n  = halt_n ? ST_DRAIN : ST_RUN;
                        enable_n = 1'b1;
                    end else begin
                        enable_n = bus.i_step;
                    end
                end
                ST_DONE: begin
                    if (bus.i_clear) begin
                        state_n   = ST_IDLE;
                        halt_n    = 1'b0;
                        drain_n   = '0;
                        timeout_n = 1'b0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            enable    <= 1'b0;
            halt_flag <= 1'b0;
            drain_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            enable    <= enable_n;
            halt_flag <= halt_n;
            drain_cnt <= drain_n;
            timeout   <= timeout_n;
        end
    end

    enable_cycle_counter #(
        .NB_COUNT       (NB_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_counter (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (enable),
        .i_clear       (clear_done),
        .i_run_active  ((state == ST_RUN) || (state == ST_DRAIN)),
        .o_cycle_count (cycle_count),
        .o_expire      (wd_expire)
    );

    assign bus.o_enable      = enable;
    assign bus.o_state       = state;
    assign bus.o_done        = (state == ST_DONE);
    assign bus.o_timeout     = timeout;
    assign bus.o_cycle_count = cycle_count;

endmodule
